// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and FSM state encoding for board-input conditioning
package io_pkg;

  // System clock frequency the default timing constants are derived from
  localparam int CLK_HZ = 100_000_000;

  // 10 ms debounce window and 1 s long-press hold at CLK_HZ
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEFAULT_LONG_CYCLES     = CLK_HZ;

  // Debounce FSM: two stable states and one checking state per direction
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage synchroniser for one asynchronous input bit
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Plain shift chain: nothing may sit between stages or metastability settling time is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronise and debounce one button; long-press pulse under BUTTON_DEBOUNCE_LONG_PRESS_EN
module button_debounce
  import io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the logic below cannot honour
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic      s;
  db_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: count consecutive cycles of s differing from the level; any agreeing cycle restarts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt;
  logic          long_q;

  // Hold counter runs while the level is high; it steps once past the fire value and parks there so each press pulses once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else if (!level_q || fall_q) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
      long_q <= (hold_cnt == HOLD_FIRE);
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule
